// File: rtl/wb_unit.sv
// Writeback stage: selects and load-extends the result of the instruction at MEM,
// stalling upstream in a two-state FSM while a load waits for memory data.
module wb_unit #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [1:0]                      in_wd_sel,
    input  logic                            in_rf_we,
    input  logic [REG_AW-1:0]               in_wr,
    input  logic [DATA_W-1:0]               in_alu_c,
    input  logic [DATA_W-1:0]               in_pc4,
    input  logic [DATA_W-1:0]               in_imm,
    input  logic [2:0]                      in_ld_type,
    input  logic [$clog2(DATA_W/8)-1:0]     in_addr_lo,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_rvalid,
    input  logic                            flush,
    output logic                            wait_req,
    output logic                            rf_we,
    output logic [REG_AW-1:0]               rf_wr,
    output logic [DATA_W-1:0]               rf_wd,
    output logic                            bus_err
);
    localparam int AW_LO = $clog2(DATA_W/8);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_wr_q, rf_wr_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              bus_err_q, bus_err_d;

    logic              ld_miss;
    logic              commit;
    logic              wait_raw;
    logic [5:0]        wsh;
    logic [DATA_W-1:0] sh_b, sh_h, sh_w;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       ld_w;
    logic [DATA_W-1:0] ext_load;
    logic [DATA_W-1:0] sel_value;

    assign ld_miss = in_valid & (in_wd_sel == 2'd3) & ~mem_rvalid;

    // Word lane only exists for 64-bit data; a 32-bit bus has a single word.
    assign wsh  = (DATA_W == 64) ? {in_addr_lo[AW_LO-1], 5'b00000} : 6'd0;
    assign sh_b = mem_rdata >> {in_addr_lo, 3'b000};
    assign sh_h = mem_rdata >> {in_addr_lo[AW_LO-1:1], 4'b0000};
    assign sh_w = mem_rdata >> wsh;
    assign ld_b = sh_b[7:0];
    assign ld_h = sh_h[15:0];
    assign ld_w = sh_w[31:0];

    always_comb begin
        ext_load = DATA_W'($signed(ld_w));
        case (in_ld_type)
            3'b000:  ext_load = DATA_W'($signed(ld_b));
            3'b001:  ext_load = DATA_W'($signed(ld_h));
            3'b010:  ext_load = DATA_W'($signed(ld_w));
            3'b011:  ext_load = (DATA_W == 64) ? mem_rdata : DATA_W'($signed(ld_w));
            3'b100:  ext_load = DATA_W'(ld_b);
            3'b101:  ext_load = DATA_W'(ld_h);
            3'b110:  ext_load = (DATA_W == 64) ? DATA_W'(ld_w) : DATA_W'($signed(ld_w));
            default: ext_load = DATA_W'($signed(ld_w));
        endcase
    end

    always_comb begin
        case (in_wd_sel)
            2'd0:    sel_value = in_alu_c;
            2'd1:    sel_value = in_pc4;
            2'd2:    sel_value = in_imm;
            default: sel_value = ext_load;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        commit    = 1'b0;
        wait_raw  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else if (state_q == IDLE) begin
            if (ld_miss) begin
                state_d  = WAIT;
                cnt_d    = 8'd0;
                wait_raw = 1'b1;
            end else begin
                commit = 1'b1;
            end
        end else begin
            // Data arriving on the terminal count still commits.
            if (mem_rvalid) begin
                commit  = 1'b1;
                state_d = IDLE;
                cnt_d   = 8'd0;
            end else if (cnt_q == CNT_LAST) begin
                state_d   = IDLE;
                cnt_d     = 8'd0;
                bus_err_d = 1'b1;
            end else begin
                wait_raw = 1'b1;
                cnt_d    = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        rf_we_d = 1'b0;
        rf_wr_d = rf_wr_q;
        rf_wd_d = rf_wd_q;
        if (commit) begin
            rf_we_d = in_valid & in_rf_we & (in_wr != '0);
            rf_wr_d = in_wr;
            rf_wd_d = sel_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            rf_we_q   <= 1'b0;
            rf_wr_q   <= '0;
            rf_wd_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rf_we_q   <= rf_we_d;
            rf_wr_q   <= rf_wr_d;
            rf_wd_q   <= rf_wd_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign wait_req = wait_raw & rst_n;
    assign rf_we    = rf_we_q;
    assign rf_wr    = rf_wr_q;
    assign rf_wd    = rf_wd_q;
    assign bus_err  = bus_err_q;
endmodule

// File: tb/tb_wb_unit.sv
// Randomized bench for wb_unit (32-bit, TIMEOUT=4) against a behavioural load/stall model.
module tb_wb_unit;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [1:0]        in_wd_sel;
    logic              in_rf_we;
    logic [REG_AW-1:0] in_wr;
    logic [31:0]       in_alu_c, in_pc4, in_imm;
    logic [2:0]        in_ld_type;
    logic [1:0]        in_addr_lo;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic              flush;
    logic              wait_req, rf_we, bus_err;
    logic [REG_AW-1:0] rf_wr;
    logic [31:0]       rf_wd;

    int pass_cnt = 0;
    int total    = 0;

    wb_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_wd_sel(in_wd_sel),
        .in_rf_we(in_rf_we), .in_wr(in_wr), .in_alu_c(in_alu_c), .in_pc4(in_pc4),
        .in_imm(in_imm), .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
        .wait_req(wait_req), .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Load extension computed from byte/halfword arithmetic on the aligned word.
    function automatic logic [31:0] model_load(input logic [2:0] t, input int a, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * (a / 2))) & 32'hFFFF;
        case (t)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_wd_sel = 0; in_rf_we = 0; in_wr = 0;
        in_alu_c = 0; in_pc4 = 0; in_imm = 0; in_ld_type = 0; in_addr_lo = 0;
        mem_rdata = 0; mem_rvalid = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        in_valid = 1; in_wd_sel = 3; in_rf_we = 1; in_wr = 7;
        #1;
        total++;
        if (wait_req !== 1'b0) $display("FAIL reset_wait_req got=%b want=0", wait_req); else pass_cnt++;
        tick(); tick();
        total++;
        if ({rf_we, rf_wr, rf_wd, bus_err} !== '0)
            $display("FAIL reset_outputs got we=%b wr=%0d wd=%h err=%b want all 0", rf_we, rf_wr, rf_wd, bus_err);
        else pass_cnt++;
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_alu();
        in_valid = 1; in_wd_sel = 0; in_rf_we = 1; in_wr = 5; in_alu_c = 32'h1234;
        tick();
        total++;
        if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd5, 32'h1234})
            $display("FAIL alu_write got we=%b wr=%0d wd=%h want 1/5/00001234", rf_we, rf_wr, rf_wd);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_lb_ext();
        logic [31:0] want [2];
        want[0] = 32'hFFFFFF80; want[1] = 32'h00000080;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_wd_sel = 3; in_rf_we = 1; in_wr = 9;
            in_ld_type = (i == 0) ? 3'b000 : 3'b100; in_addr_lo = 2;
            mem_rdata = 32'h0080FF00; mem_rvalid = 1;
            tick();
            total++;
            if (rf_wd !== want[i] || rf_we !== 1'b1)
                $display("FAIL lb_ext_%0d got we=%b wd=%h want 1/%h", i, rf_we, rf_wd, want[i]);
            else pass_cnt++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random_immediate();
        logic [31:0] exp_wd;
        logic        exp_we;
        for (int n = 0; n < 40; n++) begin
            in_valid = ($urandom_range(0, 3) != 0); in_wd_sel = 2'($urandom_range(0, 3));
            in_rf_we = ($urandom_range(0, 3) != 0); in_wr = 5'($urandom_range(0, 31));
            in_alu_c = $urandom; in_pc4 = $urandom; in_imm = $urandom;
            in_ld_type = 3'($urandom_range(0, 6)); in_addr_lo = 2'($urandom_range(0, 3));
            mem_rdata = $urandom; mem_rvalid = 1;
            case (in_wd_sel)
                2'd0:    exp_wd = in_alu_c;
                2'd1:    exp_wd = in_pc4;
                2'd2:    exp_wd = in_imm;
                default: exp_wd = model_load(in_ld_type, int'(in_addr_lo), mem_rdata);
            endcase
            exp_we = in_valid && in_rf_we && (in_wr != 0);
            #1;
            total++;
            if (wait_req !== 1'b0) $display("FAIL rand_wait_req n=%0d got=%b want=0", n, wait_req); else pass_cnt++;
            tick();
            total++;
            if ({rf_we, rf_wd} !== {exp_we, exp_wd} || (exp_we && rf_wr !== in_wr))
                $display("FAIL rand_write n=%0d got we=%b wr=%0d wd=%h want we=%b wr=%0d wd=%h",
                         n, rf_we, rf_wr, rf_wd, exp_we, in_wr, exp_wd);
            else pass_cnt++;
        end
        idle_inputs();
        tick();
    endtask

    // d = cycles after in_valid at which rvalid rises; d > TIMEOUT means never.
    task automatic test_delayed_load();
        logic [31:0] exp_wd;
        int          d, waits, exp_waits;
        bit          done;
        for (int n = 0; n < 24; n++) begin
            d = (n < 2) ? (n == 0 ? 3 : 6) : $urandom_range(0, 6);
            in_valid = 1; in_wd_sel = 3; in_rf_we = 1; in_wr = 5'($urandom_range(1, 31));
            in_ld_type = 3'($urandom_range(0, 6)); in_addr_lo = 2'($urandom_range(0, 3));
            waits = 0; done = 0; exp_wd = 0;
            exp_waits = (d <= TIMEOUT) ? d : TIMEOUT;
            for (int k = 0; k < 10 && !done; k++) begin
                mem_rvalid = (k == d);
                mem_rdata  = $urandom;
                if (k == d) exp_wd = model_load(in_ld_type, int'(in_addr_lo), mem_rdata);
                #1;
                if (wait_req) begin
                    waits++;
                    tick();
                    total++;
                    if (rf_we !== 1'b0 || bus_err !== 1'b0)
                        $display("FAIL wait_quiet n=%0d k=%0d got we=%b err=%b want 0/0", n, k, rf_we, bus_err);
                    else pass_cnt++;
                end else begin
                    done = 1;
                    tick();
                end
            end
            total++;
            if (!done || waits != exp_waits)
                $display("FAIL wait_len n=%0d d=%0d got=%0d want=%0d", n, d, waits, exp_waits);
            else pass_cnt++;
            total++;
            if (d <= TIMEOUT) begin
                if ({rf_we, bus_err, rf_wr, rf_wd} !== {1'b1, 1'b0, in_wr, exp_wd})
                    $display("FAIL load_commit n=%0d got we=%b err=%b wr=%0d wd=%h want 1/0/%0d/%h",
                             n, rf_we, bus_err, rf_wr, rf_wd, in_wr, exp_wd);
                else pass_cnt++;
            end else begin
                if (rf_we !== 1'b0 || bus_err !== 1'b1)
                    $display("FAIL timeout n=%0d got we=%b err=%b want 0/1", n, rf_we, bus_err);
                else pass_cnt++;
            end
            idle_inputs();
            tick();
            total++;
            if (bus_err !== 1'b0 || rf_we !== 1'b0)
                $display("FAIL post_load n=%0d got we=%b err=%b want 0/0", n, rf_we, bus_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_reg0_flush();
        in_valid = 1; in_wd_sel = 1; in_rf_we = 1; in_wr = 0; in_pc4 = 32'hABCD0004;
        tick();
        total++;
        if (rf_we !== 1'b0) $display("FAIL reg0_we got=%b want=0", rf_we); else pass_cnt++;
        in_wd_sel = 3; in_wr = 12; mem_rvalid = 0; in_ld_type = 3'b010;
        tick();
        tick();
        flush = 1;
        #1;
        total++;
        if (wait_req !== 1'b0) $display("FAIL flush_wait_req got=%b want=0", wait_req); else pass_cnt++;
        tick();
        total++;
        if (rf_we !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL flush_out got we=%b err=%b want 0/0", rf_we, bus_err);
        else pass_cnt++;
        idle_inputs();
        in_valid = 1; in_wd_sel = 2; in_rf_we = 1; in_wr = 3; in_imm = 32'h55AA55AA;
        #1;
        total++;
        if (wait_req !== 1'b0) $display("FAIL flush_idle got wait_req=%b want=0", wait_req); else pass_cnt++;
        tick();
        total++;
        if ({rf_we, rf_wr, rf_wd, bus_err} !== {1'b1, 5'd3, 32'h55AA55AA, 1'b0})
            $display("FAIL after_flush got we=%b wr=%0d wd=%h err=%b want 1/3/55aa55aa/0", rf_we, rf_wr, rf_wd, bus_err);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_wait();
        int errs;
        in_valid = 1; in_wd_sel = 3; in_rf_we = 1; in_wr = 20; mem_rvalid = 0;
        tick(); tick();
        rst_n = 0;
        #1;
        total++;
        if (wait_req !== 1'b0) $display("FAIL rst_wait_req got=%b want=0", wait_req); else pass_cnt++;
        tick();
        total++;
        if ({rf_we, rf_wr, rf_wd, bus_err} !== '0)
            $display("FAIL rst_mid_wait got we=%b wr=%0d wd=%h err=%b want all 0", rf_we, rf_wr, rf_wd, bus_err);
        else pass_cnt++;
        rst_n = 1;
        idle_inputs();
        errs = 0;
        for (int k = 0; k < TIMEOUT + 2; k++) begin
            tick();
            if (bus_err !== 1'b0 || rf_we !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL rst_dropped got %0d bad cycles want 0", errs); else pass_cnt++;
        in_valid = 1; in_wd_sel = 0; in_rf_we = 1; in_wr = 17; in_alu_c = 32'hC0FFEE01;
        tick();
        total++;
        if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd17, 32'hC0FFEE01})
            $display("FAIL rst_then_alu got we=%b wr=%0d wd=%h want 1/17/c0ffee01", rf_we, rf_wr, rf_wd);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        @(posedge clk); #1;
        test_reset();
        test_alu();
        test_lb_ext();
        test_random_immediate();
        test_delayed_load();
        test_reg0_flush();
        test_reset_wait();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
